// File: rtl/uart_dbg_pkg.sv
// Shared constants, FSM state encoding and TX request payload for the UART debug controller.
package uart_dbg_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 32;

    localparam logic [BYTE_W-1:0] CMD_LOAD = 8'h4C;
    localparam logic [BYTE_W-1:0] CMD_RUN  = 8'h52;
    localparam logic [BYTE_W-1:0] CMD_STEP = 8'h53;
    localparam logic [BYTE_W-1:0] CMD_DUMP = 8'h44;
    localparam logic [BYTE_W-1:0] CMD_CLR  = 8'h43;
    localparam logic [BYTE_W-1:0] ACK      = 8'h06;
    localparam logic [BYTE_W-1:0] NAK      = 8'h15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_BYTE,
        ST_LOAD_WR,
        ST_RUN,
        ST_STEP,
        ST_DUMP_SET,
        ST_DUMP_TX,
        ST_SEND
    } state_t;

    typedef struct packed {
        logic [WORD_W-1:0] word;
        logic              one_byte;
    } tx_req_t;

    // Single-byte response request for the TX serializer.
    function automatic tx_req_t resp_req(input logic [BYTE_W-1:0] b);
        tx_req_t req;
        req.word     = {24'h000000, b};
        req.one_byte = 1'b1;
        return req;
    endfunction

endpackage

// File: rtl/uart_dbg_ctrl_if.sv
// UART FIFO side of the debug controller: RX pop and TX push handshakes.
interface uart_dbg_ctrl_if;
    import uart_dbg_pkg::*;

    logic              rx_empty;
    logic [BYTE_W-1:0] r_data;
    logic              rd_uart;
    logic              tx_full;
    logic [BYTE_W-1:0] w_data;
    logic              wr_uart;

    modport master (
        input  rx_empty, r_data, tx_full,
        output rd_uart, w_data, wr_uart
    );

    modport slave (
        output rx_empty, r_data, tx_full,
        input  rd_uart, w_data, wr_uart
    );

endinterface

// File: rtl/uart_dbg_txser.sv
// Serializes a 32-bit word (LSB first) or a single byte into the TX FIFO, stalling on tx_full.
module uart_dbg_txser
    import uart_dbg_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_start,
    input  tx_req_t           i_req,
    input  logic              i_tx_full,
    output logic              o_busy,
    output logic [BYTE_W-1:0] o_w_data,
    output logic              o_wr_uart_c
);

    logic [WORD_W-1:0] r_word;
    logic [1:0]        r_left;
    logic              r_busy;
    logic              w_push;

    assign w_push      = r_busy && !i_tx_full;
    assign o_wr_uart_c = w_push;
    assign o_busy      = r_busy;
    assign o_w_data    = r_word[BYTE_W-1:0];

    // Head byte stays put until the FIFO accepts it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_word <= '0;
            r_left <= 2'd0;
            r_busy <= 1'b0;
        end else if (i_start && !r_busy) begin
            r_word <= i_req.word;
            r_left <= i_req.one_byte ? 2'd0 : 2'd3;
            r_busy <= 1'b1;
        end else if (w_push) begin
            if (r_left == 2'd0) begin
                r_busy <= 1'b0;
            end else begin
                r_word <= r_word >> BYTE_W;
                r_left <= r_left - 2'd1;
            end
        end
    end

endmodule

// File: rtl/uart_dbg_ctrl.sv
// UART command sequencer: loads IMEM, runs/steps the CPU and dumps the debug window.
// Optional load-frame idle timeout enabled by defining UART_DBG_TIMEOUT_EN.
module uart_dbg_ctrl
    import uart_dbg_pkg::*;
#(
    parameter int unsigned DBIT        = 8,
    parameter int unsigned IMEM_AW     = 8,
    parameter int unsigned DBG_AW      = 5,
    parameter int unsigned TIMEOUT_CYC = 5000000
) (
    input  logic                clk,
    input  logic                reset,
    uart_dbg_ctrl_if.master     uart,
    output logic                imem_we,
    output logic [IMEM_AW-1:0]  imem_addr,
    output logic [WORD_W-1:0]   imem_wdata,
    output logic                cpu_en,
    input  logic                cpu_halt,
    output logic [DBG_AW-1:0]   dbg_addr,
    input  logic [WORD_W-1:0]   dbg_data
);

    state_t              r_state;
    logic [1:0]          r_bcnt;
    logic [WORD_W-1:0]   r_word;
    logic [IMEM_AW-1:0]  r_ptr;
    logic                r_imem_we;
    logic                r_cpu_en;
    logic [DBG_AW-1:0]   r_dbg_addr;
    logic                r_tx_start;
    tx_req_t             r_tx_req;

    logic                w_pop;
    logic                w_timeout;
    logic                w_tx_busy;
    logic                w_tx_idle;
    logic [DBIT-1:0]     w_rx_byte;

    // RX is only popped while waiting for a command or load data.
    assign w_pop     = !reset && !uart.rx_empty &&
                       ((r_state == ST_IDLE) || (r_state == ST_LOAD_BYTE));
    assign w_rx_byte = uart.r_data;
    assign w_tx_idle = !r_tx_start && !w_tx_busy;

    assign uart.rd_uart = w_pop;
    assign imem_we      = r_imem_we;
    assign imem_addr    = r_ptr;
    assign imem_wdata   = r_word;
    assign cpu_en       = r_cpu_en;
    assign dbg_addr     = r_dbg_addr;

`ifdef UART_DBG_TIMEOUT_EN
    localparam int unsigned TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [TO_W-1:0] r_to_cnt;

    always_ff @(posedge clk) begin
        if (reset || w_pop || (r_state != ST_LOAD_BYTE)) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end
    end

    assign w_timeout = (r_state == ST_LOAD_BYTE) && (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));
`else
    logic w_unused_to;
    assign w_unused_to = |32'(TIMEOUT_CYC);
    assign w_timeout   = 1'b0;
`endif

    uart_dbg_txser u_txser (
        .clk        (clk),
        .reset      (reset),
        .i_start    (r_tx_start),
        .i_req      (r_tx_req),
        .i_tx_full  (uart.tx_full),
        .o_busy     (w_tx_busy),
        .o_w_data   (uart.w_data),
        .o_wr_uart_c(uart.wr_uart)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_bcnt     <= 2'd0;
            r_word     <= '0;
            r_ptr      <= '0;
            r_imem_we  <= 1'b0;
            r_cpu_en   <= 1'b0;
            r_dbg_addr <= '0;
            r_tx_start <= 1'b0;
            r_tx_req   <= '0;
        end else begin
            r_imem_we  <= 1'b0;
            r_tx_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        case (w_rx_byte)
                            CMD_LOAD: begin
                                r_bcnt  <= 2'd0;
                                r_state <= ST_LOAD_BYTE;
                            end
                            CMD_RUN: begin
                                r_cpu_en <= 1'b1;
                                r_state  <= ST_RUN;
                            end
                            CMD_STEP: begin
                                r_cpu_en <= 1'b1;
                                r_state  <= ST_STEP;
                            end
                            CMD_DUMP: begin
                                r_dbg_addr <= '0;
                                r_state    <= ST_DUMP_SET;
                            end
                            CMD_CLR: begin
                                r_ptr      <= '0;
                                r_tx_req   <= resp_req(ACK);
                                r_tx_start <= 1'b1;
                                r_state    <= ST_SEND;
                            end
                            default: begin
                                r_tx_req   <= resp_req(NAK);
                                r_tx_start <= 1'b1;
                                r_state    <= ST_SEND;
                            end
                        endcase
                    end
                end
                ST_LOAD_BYTE: begin
                    if (w_pop) begin
                        r_word <= {w_rx_byte, r_word[WORD_W-1:BYTE_W]};
                        r_bcnt <= r_bcnt + 2'd1;
                        if (r_bcnt == 2'd3) begin
                            r_imem_we <= 1'b1;
                            r_state   <= ST_LOAD_WR;
                        end
                    end else if (w_timeout) begin
                        r_word     <= '0;
                        r_tx_req   <= resp_req(NAK);
                        r_tx_start <= 1'b1;
                        r_state    <= ST_SEND;
                    end
                end
                ST_LOAD_WR: begin
                    r_ptr      <= r_ptr + IMEM_AW'(1);
                    r_tx_req   <= resp_req(ACK);
                    r_tx_start <= 1'b1;
                    r_state    <= ST_SEND;
                end
                ST_RUN: begin
                    if (cpu_halt) begin
                        r_cpu_en   <= 1'b0;
                        r_tx_req   <= resp_req(ACK);
                        r_tx_start <= 1'b1;
                        r_state    <= ST_SEND;
                    end
                end
                ST_STEP: begin
                    r_cpu_en   <= 1'b0;
                    r_tx_req   <= resp_req(ACK);
                    r_tx_start <= 1'b1;
                    r_state    <= ST_SEND;
                end
                ST_DUMP_SET: begin
                    r_tx_req.word     <= dbg_data;
                    r_tx_req.one_byte <= 1'b0;
                    r_tx_start        <= 1'b1;
                    r_state           <= ST_DUMP_TX;
                end
                ST_DUMP_TX: begin
                    if (w_tx_idle) begin
                        if (r_dbg_addr == {DBG_AW{1'b1}}) begin
                            r_tx_req   <= resp_req(ACK);
                            r_tx_start <= 1'b1;
                            r_state    <= ST_SEND;
                        end else begin
                            r_dbg_addr <= r_dbg_addr + DBG_AW'(1);
                            r_state    <= ST_DUMP_SET;
                        end
                    end
                end
                ST_SEND: begin
                    if (w_tx_idle) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
